// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//   master : pipeline side (drives the request, sees busy/done/hi/lo)
//   slave  : muldiv_unit side
// Signals
//   start   request strobe; op/src_a/src_b are sampled with it
//   op      AluControl code (17 mthi, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu)
//   src_a   rs operand: multiplicand / dividend / mthi-mtlo data
//   src_b   rt operand: multiplier / divisor
//   cancel  pipeline flush, aborts an in-flight operation
//   busy    unit is working, pipeline must stall
//   done    one-cycle pulse, hi/lo hold a fresh mult/div result
//   hi, lo  HI/LO architectural registers
// -----------------------------------------------------------------------------
interface muldiv_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 6
);
   logic              start;
   logic [CTRL_W-1:0] op;
   logic [WIDTH-1:0]  src_a;
   logic [WIDTH-1:0]  src_b;
   logic              cancel;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative MIPS multiply/divide unit owning the HI/LO registers.
//   mult/multu/div/divu take WIDTH+1 clock edges from the start edge to the
//   result edge (one bit per cycle, then a sign-fix cycle); mthi/mtlo write
//   HI/LO on the start edge itself.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave : start/op/src_a/src_b/cancel in,
//                            busy/done/hi/lo out (all registered)
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 6
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [CTRL_W-1:0] OP_MTHI  = CTRL_W'(17);
   localparam logic [CTRL_W-1:0] OP_MTLO  = CTRL_W'(19);
   localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(24);
   localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(25);
   localparam logic [CTRL_W-1:0] OP_DIV   = CTRL_W'(26);
   localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(27);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_is_div;
   logic               r_neg_q;    // negate product (mult) or quotient (div)
   logic               r_neg_r;    // negate remainder (div only)
   logic [WIDTH-1:0]   r_b;        // |multiplier| or |divisor|
   logic [WIDTH-1:0]   r_q;        // multiplier bits / dividend-then-quotient
   logic [WIDTH-1:0]   r_acc;      // product upper half / partial remainder

   logic               w_is_md;
   logic               w_is_signed;
   logic               w_is_div;
   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_q_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   // Two's-complement negation used for all sign fix-ups.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return {WIDTH{1'b0}} - v;
   endfunction

   // Decode the requested op and form operand magnitudes.
   always_comb begin
      w_is_md     = 1'b0;
      w_is_signed = 1'b0;
      w_is_div    = 1'b0;
      case (bus.op)
         OP_MULT:  begin w_is_md = 1'b1; w_is_signed = 1'b1; end
         OP_MULTU: begin w_is_md = 1'b1; end
         OP_DIV:   begin w_is_md = 1'b1; w_is_signed = 1'b1; w_is_div = 1'b1; end
         OP_DIVU:  begin w_is_md = 1'b1; w_is_div = 1'b1; end
         default:  begin w_is_md = 1'b0; end
      endcase
      w_sign_a = w_is_signed & bus.src_a[WIDTH-1];
      w_sign_b = w_is_signed & bus.src_b[WIDTH-1];
      // |min| wraps to min, which is the correct unsigned magnitude.
      w_abs_a  = w_sign_a ? neg_w(bus.src_a) : bus.src_a;
      w_abs_b  = w_sign_b ? neg_w(bus.src_b) : bus.src_b;
   end

   // One iteration: shift-add step for multiply, restoring step for divide.
   always_comb begin
      w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
      w_shift = {r_acc, r_q[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_b};
      if (r_is_div) begin
         // Bit WIDTH of the difference set means shift < divisor: restore.
         if (!w_diff[WIDTH]) begin
            w_acc_nxt = w_diff[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Shift {carry, acc, multiplier} right; low product bits fill r_q.
         w_acc_nxt = w_add[WIDTH:1];
         w_q_nxt   = {w_add[0], r_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up of the raw magnitudes into HI/LO values.
   always_comb begin
      w_prod   = {r_acc, r_q};
      w_prod_s = r_neg_q ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
      w_quot   = r_neg_q ? neg_w(r_q) : r_q;
      w_rem    = r_neg_r ? neg_w(r_acc) : r_acc;
      if (r_is_div) begin
         w_fix_hi = w_rem;
         w_fix_lo = w_quot;
      end else begin
         w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod_s[WIDTH-1:0];
      end
   end

   // Control FSM, datapath registers and HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= {CNT_W{1'b0}};
         r_hi     <= {WIDTH{1'b0}};
         r_lo     <= {WIDTH{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b      <= {WIDTH{1'b0}};
         r_q      <= {WIDTH{1'b0}};
         r_acc    <= {WIDTH{1'b0}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // cancel suppresses any start presented in the same cycle.
               if (bus.start && !bus.cancel) begin
                  if (w_is_md) begin
                     r_state  <= S_CALC;
                     r_busy   <= 1'b1;
                     r_cnt    <= {CNT_W{1'b0}};
                     r_is_div <= w_is_div;
                     r_b      <= w_abs_b;
                     r_q      <= w_abs_a;
                     r_acc    <= {WIDTH{1'b0}};
                     // A zero divisor keeps an all-ones quotient and a
                     // remainder equal to the dividend, so only the
                     // remainder sign is applied in that case.
                     r_neg_q  <= (w_sign_a ^ w_sign_b) & ~(w_is_div & ~(|bus.src_b));
                     r_neg_r  <= w_is_div & w_sign_a;
                  end else if (bus.op == OP_MTHI) begin
                     r_hi <= bus.src_a;
                  end else if (bus.op == OP_MTLO) begin
                     r_lo <= bus.src_a;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (bus.cancel) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_q   <= w_q_nxt;
                  r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (r_cnt == CNT_W'(WIDTH-1)) begin
                     r_state <= S_FIX;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (!bus.cancel) begin
                  r_hi   <= w_fix_hi;
                  r_lo   <= w_fix_lo;
                  r_done <= 1'b1;
               end else begin
                  r_done <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit (WIDTH=32, CTRL_W=6).
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_pass   = 0;

   muldiv_if #(.WIDTH(32), .CTRL_W(6)) bus ();

   muldiv_unit #(.WIDTH(32), .CTRL_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns #1 after the sampling edge.
   task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait (bounded) until done is seen; counts busy cycles on the way.
   task automatic wait_done(output int busy_cyc, output bit got);
      busy_cyc = 0;
      got      = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (bus.done) begin
            got = 1'b1;
         end else begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int bc;
      bit got;
      launch(op, a, b);
      wait_done(bc, got);
      check_val({tag, ".done"}, 64'(got), 64'd1);
      check_val({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
      check_val({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
   endtask

   initial begin
      int bc;
      bit got;
      bit seen;

      bus.start  = 1'b0;
      bus.op     = 6'd0;
      bus.src_a  = 32'd0;
      bus.src_b  = 32'd0;
      bus.cancel = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst.hi",   64'(bus.hi),   64'd0);
      check_val("rst.lo",   64'(bus.lo),   64'd0);
      check_val("rst.busy", 64'(bus.busy), 64'd0);
      check_val("rst.done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // mthi / mtlo: single edge, no busy, no done
      launch(6'd17, 32'h0000_1234, 32'd0);
      check_val("mthi.hi",   64'(bus.hi),   64'h1234);
      check_val("mthi.busy", 64'(bus.busy), 64'd0);
      check_val("mthi.done", 64'(bus.done), 64'd0);
      launch(6'd19, 32'h0000_5678, 32'd0);
      check_val("mtlo.lo",   64'(bus.lo),   64'h5678);

      // multu max*max with latency/pulse checks
      launch(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(bc, got);
      check_val("multu.done", 64'(got), 64'd1);
      check_val("multu.busycyc", 64'(bc), 64'd33);
      check_val("multu.busy_at_done", 64'(bus.busy), 64'd0);
      check_val("multu.hi", 64'(bus.hi), 64'hFFFF_FFFE);
      check_val("multu.lo", 64'(bus.lo), 64'h0000_0001);
      @(posedge clk);
      #1;
      check_val("multu.pulse", 64'(bus.done), 64'd0);

      do_op("mult_m3x5",  6'd24, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
      do_op("mult_m4xm4", 6'd24, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h10);
      do_op("div_m7d2",   6'd26, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu_7d0",   6'd27, 32'd7,         32'd0,        32'h7,        32'hFFFF_FFFF);
      do_op("div_m5d0",   6'd26, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
      do_op("div_ovf",    6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
      do_op("div_7dm2",   6'd26, 32'd7,         32'hFFFF_FFFE, 32'h1,        32'hFFFF_FFFD);

      // mtlo while busy is ignored
      launch(6'd27, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 6'd19;
      bus.src_a = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(bc, got);
      check_val("mtlo_busy.done", 64'(got), 64'd1);
      check_val("mtlo_busy.lo", 64'(bus.lo), 64'd14);
      check_val("mtlo_busy.hi", 64'(bus.hi), 64'd2);

      // cancel mid-divide
      launch(6'd27, 32'd50, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check_val("cancel.busy", 64'(bus.busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      check_val("cancel.nodone", 64'(seen), 64'd0);
      check_val("cancel.hi", 64'(bus.hi), 64'd2);
      check_val("cancel.lo", 64'(bus.lo), 64'd14);

      // start together with cancel in IDLE is dropped
      @(negedge clk);
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.op     = 6'd17;
      bus.src_a  = 32'hFFFF;
      @(posedge clk);
      #1;
      bus.op = 6'd25;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      check_val("startcancel.hi",   64'(bus.hi),   64'd2);
      check_val("startcancel.busy", 64'(bus.busy), 64'd0);

      // async reset mid-multiply
      launch(6'd24, 32'd3, 32'd3);
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrst.hi",   64'(bus.hi),   64'd0);
      check_val("midrst.lo",   64'(bus.lo),   64'd0);
      check_val("midrst.busy", 64'(bus.busy), 64'd0);
      check_val("midrst.done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("midrst.after_busy", 64'(bus.busy), 64'd0);

      // back-to-back: second start presented in the done cycle
      launch(6'd25, 32'd6, 32'd7);
      wait_done(bc, got);
      check_val("b2b1.done", 64'(got), 64'd1);
      check_val("b2b1.lo", 64'(bus.lo), 64'd42);
      check_val("b2b1.hi", 64'(bus.hi), 64'd0);
      bus.start = 1'b1;
      bus.op    = 6'd27;
      bus.src_a = 32'd100;
      bus.src_b = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_val("b2b2.busy", 64'(bus.busy), 64'd1);
      wait_done(bc, got);
      check_val("b2b2.done", 64'(got), 64'd1);
      check_val("b2b2.lo", 64'(bus.lo), 64'd14);
      check_val("b2b2.hi", 64'(bus.hi), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
